div_nonrestoring: RTL and testbench

Multicycle signed 32-bit integer divider. It is the inverse-operation companion to the Booth multiplier in the multdiv unit.
- Uses radix-2 non-restoring division: one quotient bit per clock, then one fix-up cycle.
- Same start-pulse/ready-pulse handshake as the multiplier. The multdiv wrapper drives both units from one operand bus and muxes results by operation.

---
 rtl/div_pkg.sv | 7 +
 rtl/div_step.sv | 20 ++
 rtl/div_nonrestoring.sv | 88 ++++++++
 tb/tb_div_nonrestoring.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default sizing for the non-restoring divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;
  localparam int ITER_LAST = WIDTH_DEF - 1;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 non-restoring iteration on {A,Q} with divisor M
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_a_next,
  output logic [WIDTH-1:0] o_q_next
);
  logic [WIDTH:0] w_sh;
  // shift {A,Q} left, add or subtract M by the sign of the old A, new quotient bit is ~sign
  always_comb begin
    w_sh = {i_a[WIDTH-1:0], i_q[WIDTH-1]};
    o_a_next = i_a[WIDTH] ? w_sh + {1'b0, i_m} : w_sh - {1'b0, i_m};
    o_q_next = {i_q[WIDTH-2:0], ~o_a_next[WIDTH]};
  end
endmodule

// File: rtl/div_nonrestoring.sv
// div_nonrestoring: multicycle signed divider; DIV_EARLY_ZERO_EN sends divide-by-zero straight to DONE
module div_nonrestoring
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             newDiv,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] data_out,
  output logic             result_ready,
  output logic             data_exception,
  output logic             busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH == WIDTH_DEF ? ITER_LAST : WIDTH - 1);
  state_t r_state, w_next;
  logic r_go, r_sign, r_div0;
  logic [WIDTH:0] r_a, w_a_next;
  logic [WIDTH-1:0] r_q, r_m, w_q_next;
  logic [CNT_W-1:0] r_cnt;
  div_step #(.WIDTH(WIDTH)) u_step (
    .i_a(r_a),
    .i_q(r_q),
    .i_m(r_m),
    .o_a_next(w_a_next),
    .o_q_next(w_q_next)
  );
  // state register
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  // next state: a start spends one setup cycle in IDLE (r_go) before iterating; a new start always restarts
  always_comb begin
    w_next = IDLE;
    case (r_state)
`ifdef DIV_EARLY_ZERO_EN
      IDLE: w_next = r_go ? (r_div0 ? DONE : RUN) : IDLE;
`else
      IDLE: w_next = r_go ? RUN : IDLE;
`endif
      RUN: w_next = (r_cnt == LAST) ? FIXUP : RUN;
      FIXUP: w_next = DONE;
      default: w_next = IDLE;
    endcase
    if (newDiv) w_next = IDLE;
    result_ready = r_state == DONE;
    busy = r_state == RUN || r_state == FIXUP;
  end
  // operand capture as magnitudes, one iteration per RUN cycle, sign and zero fix-up in FIXUP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_go <= 1'b0;
      r_a <= '0;
      r_q <= '0;
      r_m <= '0;
      r_sign <= 1'b0;
      r_div0 <= 1'b0;
      r_cnt <= '0;
      data_out <= '0;
      data_exception <= 1'b0;
    end else begin
      r_go <= newDiv;
      if (newDiv) begin
        r_a <= '0;
        r_q <= dividend[WIDTH-1] ? -dividend : dividend;
        r_m <= divisor[WIDTH-1] ? -divisor : divisor;
        r_sign <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        r_div0 <= divisor == '0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_a <= w_a_next;
        r_q <= w_q_next;
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state == FIXUP) begin
        r_a <= r_a[WIDTH] ? r_a + {1'b0, r_m} : r_a;
        data_out <= r_div0 ? '0 : r_sign ? -r_q : r_q;
        data_exception <= r_div0;
      end
`ifdef DIV_EARLY_ZERO_EN
      else if (r_state == IDLE && r_go && r_div0) begin
        data_out <= '0;
        data_exception <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_div_nonrestoring.sv
// tb_div_nonrestoring: randomized and directed checks of div_nonrestoring against an arithmetic model
module tb_div_nonrestoring;
`ifdef DIV_EARLY_ZERO_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, newDiv = 1'b0;
  logic [31:0] dividend = '0, divisor = '0, data_out;
  logic result_ready, data_exception, busy;
  int n_chk = 0, n_fail = 0;
  int m_k = -1, m_lat = 34;
  logic [31:0] m_q = '0, m_out = '0;
  logic m_e = 1'b0, m_exc = 1'b0;

  always #5 clk = ~clk;

  div_nonrestoring dut (
    .clk(clk),
    .reset(reset),
    .newDiv(newDiv),
    .dividend(dividend),
    .divisor(divisor),
    .data_out(data_out),
    .result_ready(result_ready),
    .data_exception(data_exception),
    .busy(busy)
  );

  function automatic logic [31:0] model_q(input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return 32'h0;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
    return 32'(sa / sb);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // model: edges since the last accepted start; result becomes visible when the latency elapses
  always @(posedge clk) begin
    if (reset) begin
      m_k <= -1;
      m_out <= '0;
      m_exc <= 1'b0;
    end else if (newDiv) begin
      m_k <= 0;
      m_q <= model_q(dividend, divisor);
      m_e <= divisor == 0;
      m_lat <= (EARLY && divisor == 0) ? 1 : 34;
    end else if (m_k >= 0 && m_k < m_lat) begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_lat) begin
        m_out <= m_q;
        m_exc <= m_e;
      end
    end else m_k <= -1;
  end

  initial forever begin
    @(negedge clk);
    check("ready", 32'(result_ready), 32'(m_k == m_lat));
    check("busy", 32'(busy), 32'(m_lat == 34 && m_k >= 1 && m_k <= 33));
    if (m_k == m_lat || m_k < 0) begin
      check("data_out", data_out, m_out);
      check("exception", 32'(data_exception), 32'(m_exc));
    end
  end

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    newDiv = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    newDiv = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_q, input logic exp_e);
    int n;
    start(a, b);
    n = 0;
    while (!result_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), (b == 0 && EARLY) ? 32'd1 : 32'd34);
    check("quotient", data_out, exp_q);
    check("div0_flag", 32'(data_exception), 32'(exp_e));
    @(negedge clk);
  endtask

  task automatic pick(output logic [31:0] a, output logic [31:0] b);
    int r;
    r = $urandom_range(0, 9);
    a = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
    b = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFF_FFFF : (r < 5) ? 32'($urandom_range(1, 20)) : $urandom;
    if (r >= 2 && r < 5 && $urandom_range(0, 1) == 1) b = -b;
  endtask

  initial begin
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    check("reset_data_out", data_out, 32'h0);
    check("reset_ready", 32'(result_ready), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    check("model_100_7", model_q(32'd100, 32'd7), 32'h0000_000E);
    check("model_m100_7", model_q(32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFF2);
    check("model_min_m1", model_q(32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("model_7_0", model_q(32'd7, 32'd0), 32'h0);
    run_op(32'd100, 32'd7, 32'h0000_000E, 1'b0);
    run_op(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
    run_op(32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 1'b0);
    run_op(32'd7, 32'd0, 32'h0, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0);
    run_op(32'd0, 32'd5, 32'h0, 1'b0);
    start(32'd1000, 32'd10);
    repeat (9) @(negedge clk);
    run_op(32'd50, 32'd5, 32'd10, 1'b0);
    start(32'd100, 32'd7);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_data_out", data_out, 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    repeat (40) @(negedge clk);
    check("midreset_no_ready", 32'(result_ready), 32'h0);
    for (int i = 0; i < 40; i++) begin
      pick(a, b);
      if ($urandom_range(0, 3) == 0) begin
        start(a, b);
        repeat ($urandom_range(0, 36)) @(negedge clk);
        pick(a, b);
      end
      run_op(a, b, model_q(a, b), b == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
